// File: rtl/instruction_fetch.sv
// ============================================================================
// instruction_fetch : single-stage PC/IF-ID fetch with stall, redirect, wrap.
// Optional macro IF_ADDR_FAULT_EN adds address checking, HALT state, fault_o.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch #(
  parameter int unsigned MEM_DEPTH = 8,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc_plus1_o,
`ifdef IF_ADDR_FAULT_EN
  output logic        fault_o,
`endif
  output logic        if_id_valid_o
);

`ifdef IF_ADDR_FAULT_EN
  localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HALT = 2'd2} state_e;
  logic fault_q, fault_d;
`else
  localparam logic [31:0] ADDR_MASK = 32'(MEM_DEPTH - 1);
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] idpc_q, idpc_d;
  logic [31:0] idpc1_q, idpc1_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_inc;

  assign pc_inc = pc_q + 32'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      idpc_q  <= 32'd0;
      idpc1_q <= 32'd0;
      valid_q <= 1'b0;
`ifdef IF_ADDR_FAULT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      idpc_q  <= idpc_d;
      idpc1_q <= idpc1_d;
      valid_q <= valid_d;
`ifdef IF_ADDR_FAULT_EN
      fault_q <= fault_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    idpc_d  = idpc_q;
    idpc1_d = idpc1_q;
    valid_d = valid_q;
`ifdef IF_ADDR_FAULT_EN
    fault_d = fault_q;
`endif
    case (state_q)
      BOOT, RUN: begin
        if (branch_taken_i) begin
          // Redirect squashes the word fetched this cycle; IF/ID pc fields keep their values.
          instr_d = 32'd0;
          valid_d = 1'b0;
          state_d = RUN;
`ifdef IF_ADDR_FAULT_EN
          if (branch_target_i >= DEPTH_W) begin
            state_d = HALT;
            fault_d = 1'b1;
          end else begin
            pc_d = branch_target_i;
          end
`else
          pc_d = branch_target_i & ADDR_MASK;
`endif
        end else if (state_q == BOOT) begin
          state_d = RUN;
          valid_d = 1'b0;
        end else if (!stall_i) begin
`ifdef IF_ADDR_FAULT_EN
          if (pc_inc >= DEPTH_W) begin
            state_d = HALT;
            fault_d = 1'b1;
            instr_d = 32'd0;
            valid_d = 1'b0;
          end else begin
            instr_d = imem_instr_i;
            idpc_d  = pc_q;
            idpc1_d = pc_inc;
            valid_d = 1'b1;
            pc_d    = pc_inc;
          end
`else
          instr_d = imem_instr_i;
          idpc_d  = pc_q;
          idpc1_d = pc_inc;
          valid_d = 1'b1;
          pc_d    = pc_inc & ADDR_MASK;
`endif
        end
      end
`ifdef IF_ADDR_FAULT_EN
      HALT: begin
        state_d = HALT;
      end
`endif
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign imem_addr_o      = pc_q;
  assign if_id_instr_o    = instr_q;
  assign if_id_pc_o       = idpc_q;
  assign if_id_pc_plus1_o = idpc1_q;
  assign if_id_valid_o    = valid_q;
`ifdef IF_ADDR_FAULT_EN
  assign fault_o          = fault_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// tb_instruction_fetch : scoreboard bench for instruction_fetch (default build).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc1;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall;
  logic        br;
  logic [31:0] tgt;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc1;
  logic        if_valid;
  logic        stall_at_edge;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  instruction_fetch #(.MEM_DEPTH(8), .RESET_PC(32'd0)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .imem_addr_o      (imem_addr),
    .imem_instr_i     (imem_instr),
    .stall_i          (stall),
    .branch_taken_i   (br),
    .branch_target_i  (tgt),
    .if_id_instr_o    (if_instr),
    .if_id_pc_o       (if_pc),
    .if_id_pc_plus1_o (if_pc1),
    .if_id_valid_o    (if_valid)
  );

  always #5 clk = ~clk;

  // Memory model: word at address k is a tagged value so a zeroed instr is visible.
  assign imem_instr = 32'h1000_0000 + imem_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input int k);
    exp_t e;
    e.instr = 32'h1000_0000 + 32'(k);
    e.pc    = 32'(k);
    e.pc1   = 32'(k) + 32'd1;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic s, input logic b, input logic [31:0] t);
    @(negedge clk);
    stall = s;
    br    = b;
    tgt   = t;
    @(posedge clk);
    #1;
  endtask

  // Monitor: a valid output after an edge with stall low is a fresh capture.
  always @(posedge clk) begin
    stall_at_edge = stall;
    #1;
    if (if_valid === 1'b1 && stall_at_edge === 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_capture", if_pc, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_instr", if_instr, e.instr);
        chk("sb_pc", if_pc, e.pc);
        chk("sb_pc1", if_pc1, e.pc1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    br    = 1'b0;
    tgt   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_pc1", if_pc1, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("boot_valid", {31'd0, if_valid}, 32'd0);
    chk("boot_addr", imem_addr, 32'd0);

    for (int k = 0; k < 10; k++) begin
      push(k % 8);
      cyc(1'b0, 1'b0, 32'd0);
      if (k == 7) chk("wrap_addr", imem_addr, 32'd0);
    end

    push(2);
    cyc(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 32'd0);
      chk("stall_addr", imem_addr, 32'd3);
      chk("stall_pc", if_pc, 32'd2);
      chk("stall_valid", {31'd0, if_valid}, 32'd1);
    end
    push(3);
    cyc(1'b0, 1'b0, 32'd0);
    chk("unstall_addr", imem_addr, 32'd4);

    cyc(1'b0, 1'b1, 32'd3);
    chk("br_valid", {31'd0, if_valid}, 32'd0);
    chk("br_instr", if_instr, 32'd0);
    chk("br_addr", imem_addr, 32'd3);
    chk("br_pc_kept", if_pc, 32'd3);

    cyc(1'b1, 1'b1, 32'd5);
    chk("brst_valid", {31'd0, if_valid}, 32'd0);
    chk("brst_addr", imem_addr, 32'd5);
    chk("brst_pc1_kept", if_pc1, 32'd4);
    push(5);
    cyc(1'b0, 1'b0, 32'd0);
    chk("after_br_addr", imem_addr, 32'd6);

    #3;
    rst_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, if_valid}, 32'd0);
    chk("async_instr", if_instr, 32'd0);
    chk("async_pc", if_pc, 32'd0);
    chk("async_pc1", if_pc1, 32'd0);
    chk("async_addr", imem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reboot_valid", {31'd0, if_valid}, 32'd0);
    chk("reboot_addr", imem_addr, 32'd0);
    push(0);
    cyc(1'b0, 1'b0, 32'd0);
    chk("reboot_next_addr", imem_addr, 32'd1);

    cyc(1'b0, 1'b1, 32'd9);
    chk("mask_addr", imem_addr, 32'd1);
    chk("mask_valid", {31'd0, if_valid}, 32'd0);
    push(1);
    cyc(1'b0, 1'b0, 32'd0);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    br    = 1'b1;
    tgt   = 32'd6;
    @(posedge clk);
    #1;
    chk("bootbr_addr", imem_addr, 32'd6);
    chk("bootbr_valid", {31'd0, if_valid}, 32'd0);
    push(6);
    cyc(1'b0, 1'b0, 32'd0);
    push(7);
    cyc(1'b0, 1'b0, 32'd0);
    chk("final_addr", imem_addr, 32'd0);

    cyc(1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b0, 32'd0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter MEM_DEPTH, default 8: instruction memory depth in words; SHALL be a power of two.
REQ-002 Parameter RESET_PC, default 0: word address of the first fetch after reset.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = in reset).
REQ-005 imem_addr  output  32  word address presented to the instruction memory.
REQ-006 imem_instr  input  32  instruction word returned combinationally for imem_addr.
REQ-007 stall  input  1  hazard-unit hold request.
REQ-008 branch_taken  input  1  redirect request from the branch-resolution stage.
REQ-009 branch_target  input  32  word address of the redirect.
REQ-010 if_id_instr  output  32  registered instruction to decode.
REQ-011 if_id_pc  output  32  word address of if_id_instr.
REQ-012 if_id_pc_plus1  output  32  if_id_pc + 1, computed modulo 2^32.
REQ-013 if_id_valid  output  1  1 = if_id_instr is a real instruction; 0 = bubble.
REQ-014 fault  output  1  address-fault flag; present only when IF_ADDR_FAULT_EN is defined.

Function
REQ-015 imem_addr SHALL equal the internal pc register combinationally, with no added latency.
REQ-016 The block SHALL implement the states BOOT, RUN and HALT; HALT exists only with IF_ADDR_FAULT_EN.
REQ-017 BOOT SHALL be entered on reset and SHALL last one cycle:
- no IF/ID capture; if_id_valid=0
- pc held at RESET_PC
- next state RUN
REQ-018 In RUN with stall=0 and branch_taken=0, each edge SHALL:
- capture imem_instr, pc and pc+1 into IF/ID
- set if_id_valid=1
- advance pc to the next sequential address
REQ-019 Fetch-to-decode latency SHALL be one cycle: the word at address A appears on if_id_instr on the edge after imem_addr=A.
REQ-020 In RUN with stall=1 and branch_taken=0, pc and all IF/ID outputs SHALL hold their values.
REQ-021 branch_taken=1 in BOOT or RUN SHALL:
- load pc with the redirect address
- write a bubble into IF/ID: if_id_instr=0, if_id_valid=0, if_id_pc and if_id_pc_plus1 unchanged
- go to RUN
REQ-022 branch_taken SHALL take priority over a simultaneous stall; a branch_taken arriving in BOOT SHALL still be honoured.
REQ-023 The instruction captured in the redirect cycle SHALL be discarded and never appear with if_id_valid=1.
REQ-024 Sequential next pc SHALL be (pc+1) mod MEM_DEPTH, so MEM_DEPTH-1 wraps to 0.
REQ-025 The redirect address SHALL be branch_target mod MEM_DEPTH when IF_ADDR_FAULT_EN is undefined.
REQ-026 stall and branch_taken SHALL be ignored in HALT.

Reset
REQ-027 While rst=0, the block SHALL immediately, without waiting for a clock edge, force:
- pc=RESET_PC
- if_id_instr=0, if_id_pc=0, if_id_pc_plus1=0, if_id_valid=0
- fault=0
- state=BOOT
REQ-028 Reset asserted mid-operation SHALL abandon any stall, redirect or fault in progress.
REQ-029 The first edge after rst returns to 1 SHALL execute BOOT.

Configuration
REQ-030 Macro IF_ADDR_FAULT_EN, when defined, SHALL enable address checking.
- Redirect is unmasked: branch_target >= MEM_DEPTH enters HALT.
- Sequential pc+1 >= MEM_DEPTH enters HALT instead of wrapping.
- On entry to HALT: fault=1, IF/ID holds a bubble, pc freezes at the last legal address; exit only by reset.
REQ-031 Without IF_ADDR_FAULT_EN:
- no fault port and no HALT state
- wrap and mask behaviour as in REQ-024 and REQ-025

Verification
REQ-032 Reset release, imem returning word k at address k, no stall or branch -> cycle 1 is a bubble; then if_id_pc=0,1,2... with if_id_valid=1; after address 7, imem_addr returns to 0.
REQ-033 stall=1 for 3 cycles while if_id_pc=2 -> imem_addr=3 and if_id_pc=2 hold for 3 cycles; if_id_pc=3 on the next edge.
REQ-034 branch_taken=1, branch_target=5, stall=1 in the same cycle at pc=3 -> next edge: if_id_valid=0, imem_addr=5; following edge: if_id_pc=5, valid=1.
REQ-035 rst driven 0 between clock edges while if_id_valid=1 -> all outputs return to reset values immediately; after release, one BOOT bubble, then if_id_pc=0.
REQ-036 With IF_ADDR_FAULT_EN, branch_target=9 -> fault=1 and if_id_valid=0 held until reset; without the macro, the same stimulus -> imem_addr=1.
